// File: rtl/seq_alu_unit.sv
// Multi-cycle ALU: single-cycle ops finish at the accept edge; signed Booth MUL and restoring DIV take WIDTH clocks.
// start is only sampled while idle; busy covers every iteration and done pulses once per op.
module seq_alu_unit #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_start,
  input  logic [4:0]       i_opcode,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_z_hi,
  output logic [WIDTH-1:0] o_z_lo,
  output logic             o_div_by_zero
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_SHR = 5'b00101;
  localparam logic [4:0] OP_SHL = 5'b00110;
  localparam logic [4:0] OP_ROR = 5'b00111;
  localparam logic [4:0] OP_ROL = 5'b01000;
  localparam logic [4:0] OP_AND = 5'b01001;
  localparam logic [4:0] OP_OR  = 5'b01010;
  localparam logic [4:0] OP_MUL = 5'b01110;
  localparam logic [4:0] OP_DIV = 5'b01111;
  localparam logic [4:0] OP_NEG = 5'b10000;
  localparam logic [4:0] OP_NOT = 5'b10001;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           r_state, w_state_nxt;
  logic             w_busy_nxt, w_done_nxt, w_last;
  logic [SHW:0]     r_cnt;
  logic [WIDTH:0]   r_hi;
  logic [WIDTH-1:0] r_lo, r_m, r_a;
  logic             r_qm1, r_neg_q, r_neg_r, r_bz;
  logic             r_busy, r_done, r_dbz;
  logic [WIDTH-1:0] r_z_hi, r_z_lo;

  logic [SHW-1:0]     w_sh;
  logic [2*WIDTH-1:0] w_dbl;
  logic [WIDTH-1:0]   w_alu, w_a_abs, w_b_abs;
  logic [WIDTH:0]     w_m_ext, w_bsum, w_mhi_nxt;
  logic [WIDTH-1:0]   w_mlo_nxt;
  logic [WIDTH:0]     w_dshift;
  logic               w_dge;
  logic [WIDTH-1:0]   w_drem, w_dquo, w_q_fin, w_r_fin;

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_z_hi        = r_z_hi;
  assign o_z_lo        = r_z_lo;
  assign o_div_by_zero = r_dbz;

  assign w_last = (r_cnt == CNT_ONE);

  always_ff @(posedge i_clk) begin
    if (i_clr) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_opcode == OP_MUL) begin
            w_state_nxt = S_MUL;
            w_busy_nxt  = 1'b1;
          end else if (i_opcode == OP_DIV) begin
            w_state_nxt = S_DIV;
            w_busy_nxt  = 1'b1;
          end else begin
            w_done_nxt  = 1'b1;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (w_last) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_busy_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Rotates use a doubled operand so the wrapped bits fall out of a plain shift.
  always_comb begin
    w_sh  = i_b[SHW-1:0];
    w_dbl = {i_a, i_a};
    w_alu = '0;
    case (i_opcode)
      OP_ADD:  w_alu = i_a + i_b;
      OP_SUB:  w_alu = i_a - i_b;
      OP_SHR:  w_alu = i_a >> w_sh;
      OP_SHL:  w_alu = i_a << w_sh;
      OP_ROR:  w_alu = WIDTH'(w_dbl >> w_sh);
      OP_ROL:  w_alu = WIDTH'((w_dbl << w_sh) >> WIDTH);
      OP_AND:  w_alu = i_a & i_b;
      OP_OR:   w_alu = i_a | i_b;
      OP_NEG:  w_alu = -i_b;
      OP_NOT:  w_alu = ~i_b;
      default: w_alu = '0;
    endcase
  end

  assign w_a_abs = i_a[WIDTH-1] ? -i_a : i_a;
  assign w_b_abs = i_b[WIDTH-1] ? -i_b : i_b;

  // Booth step: r_hi carries one guard bit so adding/subtracting MIN cannot overflow.
  assign w_m_ext = {r_m[WIDTH-1], r_m};
  always_comb begin
    case ({r_lo[0], r_qm1})
      2'b01:   w_bsum = r_hi + w_m_ext;
      2'b10:   w_bsum = r_hi - w_m_ext;
      default: w_bsum = r_hi;
    endcase
  end
  assign w_mhi_nxt = {w_bsum[WIDTH], w_bsum[WIDTH:1]};
  assign w_mlo_nxt = {w_bsum[0], r_lo[WIDTH-1:1]};

  // Restoring divide on magnitudes; r_lo shifts the dividend out and the quotient in.
  assign w_dshift = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
  assign w_dge    = (w_dshift >= {1'b0, r_m});
  assign w_drem   = w_dge ? WIDTH'(w_dshift - {1'b0, r_m}) : w_dshift[WIDTH-1:0];
  assign w_dquo   = {r_lo[WIDTH-2:0], w_dge};
  assign w_q_fin  = r_neg_q ? -w_dquo : w_dquo;
  assign w_r_fin  = r_neg_r ? -w_drem : w_drem;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_z_hi  <= '0;
      r_z_lo  <= '0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_m     <= '0;
      r_a     <= '0;
      r_qm1   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_bz    <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_dbz <= 1'b0;
            r_cnt <= CNT_INIT;
            r_hi  <= '0;
            r_qm1 <= 1'b0;
            if (i_opcode == OP_MUL) begin
              r_m  <= i_a;
              r_lo <= i_b;
            end else if (i_opcode == OP_DIV) begin
              r_m     <= w_b_abs;
              r_lo    <= w_a_abs;
              r_a     <= i_a;
              r_bz    <= (i_b == '0);
              r_neg_q <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
              r_neg_r <= i_a[WIDTH-1];
            end else begin
              r_z_lo <= w_alu;
              r_z_hi <= '0;
            end
          end
        end
        S_MUL: begin
          r_cnt <= r_cnt - 1'b1;
          r_hi  <= w_mhi_nxt;
          r_lo  <= w_mlo_nxt;
          r_qm1 <= r_lo[0];
          if (w_last) begin
            r_z_hi <= w_mhi_nxt[WIDTH-1:0];
            r_z_lo <= w_mlo_nxt;
          end
        end
        S_DIV: begin
          r_cnt <= r_cnt - 1'b1;
          r_hi  <= {1'b0, w_drem};
          r_lo  <= w_dquo;
          if (w_last) begin
            if (r_bz) begin
              r_z_lo <= '1;
              r_z_hi <= r_a;
              r_dbz  <= 1'b1;
            end else begin
              r_z_lo <= w_q_fin;
              r_z_hi <= w_r_fin;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu_unit.sv
// Directed bench for seq_alu_unit at WIDTH=32: vector table for single-cycle ops plus multi-cycle sequences.
module tb_seq_alu_unit;

  localparam logic [4:0] OP_NOP = 5'b00000;
  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_SHR = 5'b00101;
  localparam logic [4:0] OP_SHL = 5'b00110;
  localparam logic [4:0] OP_ROR = 5'b00111;
  localparam logic [4:0] OP_ROL = 5'b01000;
  localparam logic [4:0] OP_AND = 5'b01001;
  localparam logic [4:0] OP_OR  = 5'b01010;
  localparam logic [4:0] OP_MUL = 5'b01110;
  localparam logic [4:0] OP_DIV = 5'b01111;
  localparam logic [4:0] OP_NEG = 5'b10000;
  localparam logic [4:0] OP_NOT = 5'b10001;
  localparam logic [4:0] OP_BAD = 5'b11111;

  logic        i_clk = 1'b0;
  logic        i_clr, i_start;
  logic [4:0]  i_opcode;
  logic [31:0] i_a, i_b;
  logic        o_busy, o_done, o_div_by_zero;
  logic [31:0] o_z_hi, o_z_lo;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_lo;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  seq_alu_unit #(.WIDTH(32)) dut (
    .i_clk         (i_clk),
    .i_clr         (i_clr),
    .i_start       (i_start),
    .i_opcode      (i_opcode),
    .i_a           (i_a),
    .i_b           (i_b),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_z_hi        (o_z_hi),
    .o_z_lo        (o_z_lo),
    .o_div_by_zero (o_div_by_zero)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Issues a MUL/DIV, pulses start mid-op with junk operands, and checks timing and results.
  task automatic run_long(input string nm, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi,
                          input logic [31:0] elo, input logic edbz);
    int  cnt;
    int  bcyc;
    bit  seen;
    i_start = 1'b1; i_opcode = op; i_a = a; i_b = b;
    tick();
    chk({nm, "_busy_at_accept"}, 32'(o_busy), 32'd1);
    chk({nm, "_done_at_accept"}, 32'(o_done), 32'd0);
    chk({nm, "_dbz_cleared"}, 32'(o_div_by_zero), 32'd0);
    i_start = 1'b0; i_opcode = OP_DIV; i_a = 32'hDEADBEEF; i_b = 32'h0;
    cnt = 0; bcyc = 1; seen = 1'b0;
    while (!seen && cnt < 40) begin
      tick();
      cnt++;
      if (o_busy) bcyc++;
      if (o_done) seen = 1'b1;
      i_start = (cnt == 5);
    end
    i_start = 1'b0;
    chk({nm, "_latency"}, 32'(cnt), 32'd32);
    chk({nm, "_busy_cycles"}, 32'(bcyc), 32'd32);
    chk({nm, "_busy_at_done"}, 32'(o_busy), 32'd0);
    chk({nm, "_z_hi"}, o_z_hi, ehi);
    chk({nm, "_z_lo"}, o_z_lo, elo);
    chk({nm, "_dbz"}, 32'(o_div_by_zero), 32'(edbz));
    tick();
    chk({nm, "_done_drops"}, 32'(o_done), 32'd0);
    chk({nm, "_z_lo_holds"}, o_z_lo, elo);
    chk({nm, "_dbz_holds"}, 32'(o_div_by_zero), 32'(edbz));
  endtask

  initial begin
    vecs[0]  = '{OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000};
    vecs[1]  = '{OP_SUB, 32'h00000005, 32'h00000007, 32'hFFFFFFFE};
    vecs[2]  = '{OP_ROR, 32'h00000001, 32'h00000021, 32'h80000000};
    vecs[3]  = '{OP_SHR, 32'h80000000, 32'h00000004, 32'h08000000};
    vecs[4]  = '{OP_SHL, 32'h00000001, 32'h00000000, 32'h00000001};
    vecs[5]  = '{OP_SHL, 32'h00000001, 32'h0000001F, 32'h80000000};
    vecs[6]  = '{OP_ROL, 32'h80000000, 32'h00000001, 32'h00000001};
    vecs[7]  = '{OP_ROL, 32'h12345678, 32'h00000004, 32'h23456781};
    vecs[8]  = '{OP_ROR, 32'h12345678, 32'h00000008, 32'h78123456};
    vecs[9]  = '{OP_SHR, 32'h80000000, 32'h00000024, 32'h08000000};
    vecs[10] = '{OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
    vecs[11] = '{OP_OR,  32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0};
    vecs[12] = '{OP_NEG, 32'h12345678, 32'h00000001, 32'hFFFFFFFF};
    vecs[13] = '{OP_NEG, 32'h00000000, 32'h80000000, 32'h80000000};
    vecs[14] = '{OP_NOT, 32'h00000000, 32'h0000FFFF, 32'hFFFF0000};
    vecs[15] = '{OP_NOP, 32'h00000001, 32'h00000002, 32'h00000000};
    vecs[16] = '{OP_ADD, 32'hFFFFFFFF, 32'h00000002, 32'h00000001};
    vecs[17] = '{OP_BAD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};

    i_clr = 1'b1; i_start = 1'b0; i_opcode = OP_NOP; i_a = '0; i_b = '0;
    tick();
    tick();
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_done", 32'(o_done), 32'd0);
    chk("reset_z_hi", o_z_hi, 32'd0);
    chk("reset_z_lo", o_z_lo, 32'd0);
    chk("reset_dbz", 32'(o_div_by_zero), 32'd0);
    i_clr = 1'b0;
    tick();

    // Back-to-back single-cycle ops, one accept per clock.
    for (int i = 0; i < NVEC; i++) begin
      i_start = 1'b1; i_opcode = vecs[i].op; i_a = vecs[i].a; i_b = vecs[i].b;
      tick();
      chk($sformatf("vec%0d_done", i), 32'(o_done), 32'd1);
      chk($sformatf("vec%0d_busy", i), 32'(o_busy), 32'd0);
      chk($sformatf("vec%0d_z_hi", i), o_z_hi, 32'd0);
      chk($sformatf("vec%0d_z_lo", i), o_z_lo, vecs[i].exp_lo);
    end

    // Issued on the done cycle of the last table op.
    run_long("div_neg7_by_2", OP_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_long("mul_neg3_x7", OP_MUL, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run_long("mul_maxpos_sq", OP_MUL, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0);
    run_long("mul_min_sq", OP_MUL, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
    run_long("div_by_zero", OP_DIV, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1);
    run_long("div_min_by_m1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    run_long("div_7_by_m2", OP_DIV, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);

    // Abort a MUL partway through.
    i_start = 1'b1; i_opcode = OP_MUL; i_a = 32'd3; i_b = 32'd5;
    tick();
    i_start = 1'b0;
    repeat (9) tick();
    chk("abort_busy_before", 32'(o_busy), 32'd1);
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_done", 32'(o_done), 32'd0);
    chk("abort_z_hi", o_z_hi, 32'd0);
    chk("abort_z_lo", o_z_lo, 32'd0);
    i_start = 1'b1; i_opcode = OP_ADD; i_a = 32'd2; i_b = 32'd3;
    tick();
    chk("post_abort_add_done", 32'(o_done), 32'd1);
    chk("post_abort_add_z_lo", o_z_lo, 32'd5);

    // Reset wins over a simultaneous start.
    i_clr = 1'b1; i_start = 1'b1; i_opcode = OP_ADD; i_a = 32'd4; i_b = 32'd4;
    tick();
    i_clr = 1'b0; i_start = 1'b0;
    chk("clr_vs_start_done", 32'(o_done), 32'd0);
    chk("clr_vs_start_z_lo", o_z_lo, 32'd0);
    repeat (3) tick();
    chk("idle_no_done", 32'(o_done), 32'd0);
    chk("idle_no_busy", 32'(o_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
